apb_command_requester: RTL and testbench

APB_COMMAND_REQUESTER -- requirements
Module: APB_CommandRequester

---
 rtl/apb_command_requester_pkg.sv | 20 ++
 rtl/apb_if.sv | 52 +++++
 rtl/apb_command_requester.sv | 145 ++++++++++++++
 tb/tb_apb_command_requester.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_command_requester_pkg.sv
// Shared types and constants for the APB command requester.
// Holds the FSM state encoding, default timeout and the fixed APB data width.
package apb_command_requester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StRespond
  } state_e;

  localparam int unsigned TimeoutCyclesDefault = 1024;
  localparam int unsigned DataWidth            = 32;
  localparam int unsigned StrbWidth            = DataWidth / 8;

  function automatic logic is_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with requester and completer views.
// The clock and active-low reset travel with the bus.
interface apb_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic pclk,
  input logic preset_n
);

  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport requester (
    input  pclk,
    input  preset_n,
    input  pready,
    input  prdata,
    input  pslverr,
    output paddr,
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    output pstrb,
    output pprot
  );

  modport completer (
    input  pclk,
    input  preset_n,
    input  paddr,
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    input  pstrb,
    input  pprot,
    output pready,
    output prdata,
    output pslverr
  );

endinterface

// File: rtl/apb_command_requester.sv
// Turns single-beat commands into APB transfers and returns one response each.
// Misaligned commands fail locally; stalled transfers are aborted after TIMEOUT_CYCLES.
module apb_command_requester
  import apb_command_requester_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  apb_if.requester              apb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DataWidth-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DataWidth-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (ADDR_WIDTH < 2) begin : g_bad_addr
    $error("ADDR_WIDTH must be at least 2");
  end

  localparam int unsigned         CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DataWidth-1:0]  pwdata_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DataWidth-1:0]  rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  // Fixed-width views of the bus data: any other bus data width is a width error here.
  logic [DataWidth-1:0]  prdata;
  assign prdata = apb.prdata;

  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            if (is_aligned(cmd_addr[1:0])) begin
              psel_q  <= 1'b1;
              state_q <= StSetup;
            end else begin
              // Alignment fault is answered without touching the bus.
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= '0;
              state_q       <= StRespond;
            end
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // pready wins over the timeout on the last permitted cycle.
          if (apb.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= apb.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (pwrite_q || apb.pslverr) ? '0 : prdata;
            state_q       <= StRespond;
          end else if (cnt_q == CntLast) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= StRespond;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRespond: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            cmd_ready_q   <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = {StrbWidth{1'b1}};
  assign apb.pprot   = 3'b000;

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_command_requester.sv
// Scoreboard bench for apb_command_requester with a configurable APB completer model.
module tb_apb_command_requester;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  apb_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) apb (.pclk(clk), .preset_n(rst_n));

  apb_command_requester #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(Timeout)) dut (
    .apb         (apb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    logic        psel;
    logic [7:0]  acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_states = 0;
  logic [31:0] comp_rdata = '0;
  logic        comp_err = 1'b0;
  logic        comp_stuck = 1'b0;
  logic        comp_tied = 1'b0;
  int          acc_n = 0;
  int          acc_cycles = 0;
  logic        psel_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Completer: pready after wait_states ACCESS cycles, unless stuck or tied high.
  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (apb.psel && apb.penable) acc_n++;
      else acc_n = 0;
      apb.pready  = comp_tied ||
                    (!comp_stuck && apb.psel && apb.penable && (acc_n > wait_states));
      apb.prdata  = apb.pready ? comp_rdata : 32'h0;
      apb.pslverr = apb.pready && comp_err;
    end
  end

  // Monitor: bus activity per transaction and scoreboard compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (apb.psel) psel_seen = 1'b1;
    if (apb.psel && apb.penable) acc_cycles++;
    if (rsp_valid && rsp_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        check("psel_seen", 64'(psel_seen), 64'(e.psel));
        check("access_cycles", 64'(acc_cycles), 64'(e.acc));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, 64'(apb.psel), 64'd0);
    check({tag, "_penable"}, 64'(apb.penable), 64'd0);
    check({tag, "_pwrite"}, 64'(apb.pwrite), 64'd0);
    check({tag, "_paddr"}, 64'(apb.paddr), 64'd0);
    check({tag, "_pwdata"}, 64'(apb.pwdata), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    check({tag, "_pstrb"}, 64'(apb.pstrb), 64'hF);
    check({tag, "_pprot"}, 64'(apb.pprot), 64'd0);
  endtask

  // Starts and ends at posedge+1.
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd, input logic slv,
                         input logic stuck, input logic tied, input int hold);
    exp_t        e;
    int          lat;
    logic        ok;
    logic        aligned;
    logic [31:0] s_rdata;
    logic        s_err;
    logic        s_tmo;
    aligned     = (addr[1:0] == 2'b00);
    wait_states = waits;
    comp_rdata  = rd;
    comp_err    = slv;
    comp_stuck  = stuck;
    comp_tied   = tied;
    e.psel  = aligned;
    e.tmo   = aligned && stuck;
    e.err   = !aligned || stuck || slv;
    e.rdata = (wr || e.err) ? 32'h0 : rd;
    e.acc   = !aligned ? 8'd0 : stuck ? 8'(Timeout) : 8'(waits + 1);
    exp_q.push_back(e);
    psel_seen  = 1'b0;
    acc_cycles = 0;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 64'(ok), 64'd1);
    if (!ok) begin
      cmd_valid = 1'b0;
      void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (aligned && lat == 1) begin
        check("setup_phase", 64'({apb.psel, apb.penable}), 64'b10);
        check("paddr", 64'(apb.paddr), 64'(addr));
        check("pwrite", 64'(apb.pwrite), 64'(wr));
        check("pwdata", 64'(apb.pwdata), 64'(wdata));
      end
      if (aligned && lat == 2) check("access_phase", 64'({apb.psel, apb.penable}), 64'b11);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_seen", 64'(ok), 64'd1);
    if (!ok) begin
      @(posedge clk);
      #1;
      return;
    end
    check("latency", 64'(lat), 64'(!aligned ? 1 : stuck ? 2 + int'(Timeout) : 3 + waits));
    check("bus_released", 64'({apb.psel, apb.penable}), 64'b00);
    s_rdata = rsp_rdata;
    s_err   = rsp_err;
    s_tmo   = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_stable", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
            64'({1'b1, s_rdata, s_err, s_tmo}));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_rsp", 64'({cmd_ready, rsp_valid}), 64'b10);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_access();
    logic ok;
    comp_stuck = 1'b1;
    comp_tied  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 16'h0200;
    cmd_wdata  = 32'hA5A5_0001;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (apb.penable) begin
          ok = 1'b1;
          break;
        end
      end
    end
    check("rst_reached_access", 64'(ok), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    comp_stuck = 1'b0;
    @(negedge clk);
    check("midrst_ready_before_edge", 64'({cmd_ready, rsp_valid}), 64'b00);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_ready_after_edge", 64'({cmd_ready, rsp_valid}), 64'b10);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_edge", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    // wr, addr, wdata, waits, prdata, pslverr, stuck, tied, hold
    run_cmd(1'b1, 16'h0020, 32'h5, 0, 32'hF00D, 1'b0, 1'b0, 1'b1, 0);
    run_cmd(1'b0, 16'h0040, 32'h0, 3, 32'hB, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 16'h0002, 32'h0, 0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(1'b1, 16'h0180, 32'h77, 0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 16'h0100, 32'h0, 0, 32'h55, 1'b0, 1'b1, 1'b0, 0);
    run_cmd(1'b0, 16'h0104, 32'h0, Timeout - 1, 32'h1234, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 16'h0108, 32'h0, 1, 32'hCAFE, 1'b0, 1'b0, 1'b0, 5);
    reset_mid_access();

    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
      if (i % 3 == 2) a = a | 16'h0001;
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $urandom,
              1'(i == 4), 1'b0, 1'b0, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
